// File: rtl/scan_stimulus_gen.sv
// rtl/scan_stimulus_gen.sv - synthetic scanner head: alternating lsync/rsync, sweeps, one groove pulse per sweep
// Optional groove-position jitter from a 16-bit LFSR when SCAN_JITTER_EN is defined.
module scan_stimulus_gen #(
   parameter int              CW             = 24,
   parameter logic [CW-1:0]   DEF_SWEEP_LEN  = CW'(1000),
   parameter logic [15:0]     DEF_SYNC_W     = 16'd8,
   parameter logic [CW-1:0]   DEF_GROOVE_POS = CW'(400),
   parameter logic [15:0]     DEF_GROOVE_W   = 16'd20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [CW-1:0] cfg_sweep_len,
   input  logic [15:0]   cfg_sync_w,
   input  logic [CW-1:0] cfg_groove_pos,
   input  logic [15:0]   cfg_groove_w,
   output logic          lsync,
   output logic          rsync,
   output logic          sig,
   output logic          dir,
   output logic          busy,
   output logic [31:0]   sweep_count
`ifdef SCAN_JITTER_EN
   ,
   output logic [3:0]    jitter_ofs
`endif
);

   typedef enum logic [1:0] {IDLE, SYNC, SWEEP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          side;
   logic [CW-1:0] act_len, act_pos, pend_len, pend_pos;
   logic [15:0]   act_sw, act_gw, pend_sw, pend_gw;
   logic          pend_valid;
   logic [CW-1:0] pos_q;
   logic [CW:0]   end_q;

   logic [CW-1:0] len_eff, len_last, sw_last, cnt_inc, pos_new;
   logic [15:0]   sw_eff;
   logic [CW:0]   end_new;
   logic          sig_nxt;

`ifdef SCAN_JITTER_EN
   logic [15:0]          lfsr;
   logic [3:0]           ofs4;
   logic signed [CW+1:0] pos_sum;
`endif

   always_comb begin
      len_eff  = (act_len == '0) ? CW'(1) : act_len;
      sw_eff   = (act_sw == 16'd0) ? 16'd1 : act_sw;
      len_last = len_eff - CW'(1);
      sw_last  = {{(CW-16){1'b0}}, sw_eff - 16'd1};
      cnt_inc  = cnt + CW'(1);
`ifdef SCAN_JITTER_EN
      // lfsr[3:0]-8 as a 4-bit two's-complement value is just the MSB inverted
      ofs4    = {~lfsr[3], lfsr[2:0]};
      pos_sum = $signed({2'b00, act_pos}) + $signed({{(CW-2){ofs4[3]}}, ofs4});
      if (pos_sum < 0)
         pos_new = '0;
      else if (pos_sum > $signed({2'b00, len_last}))
         pos_new = len_last;
      else
         pos_new = pos_sum[CW-1:0];
`else
      pos_new = act_pos;
`endif
      // End bound is clamped to the sweep, so pos >= len or w == 0 yields an empty window
      end_new = {1'b0, pos_new} + {{(CW-15){1'b0}}, act_gw};
      if (end_new > {1'b0, len_eff})
         end_new = {1'b0, len_eff};
      sig_nxt = ({1'b0, cnt_inc} >= {1'b0, pos_q}) && ({1'b0, cnt_inc} < end_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         side        <= 1'b0;
         act_len     <= DEF_SWEEP_LEN;
         act_sw      <= DEF_SYNC_W;
         act_pos     <= DEF_GROOVE_POS;
         act_gw      <= DEF_GROOVE_W;
         pend_len    <= '0;
         pend_sw     <= '0;
         pend_pos    <= '0;
         pend_gw     <= '0;
         pend_valid  <= 1'b0;
         cfg_ready   <= 1'b1;
         lsync       <= 1'b0;
         rsync       <= 1'b0;
         sig         <= 1'b0;
         dir         <= 1'b0;
         busy        <= 1'b0;
         sweep_count <= '0;
         pos_q       <= '0;
         end_q       <= '0;
`ifdef SCAN_JITTER_EN
         lfsr        <= 16'hACE1;
         jitter_ofs  <= '0;
`endif
      end else begin
         if (cfg_valid && cfg_ready) begin
            pend_len   <= cfg_sweep_len;
            pend_sw    <= cfg_sync_w;
            pend_pos   <= cfg_groove_pos;
            pend_gw    <= cfg_groove_w;
            pend_valid <= 1'b1;
            cfg_ready  <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (enable) begin
                  state <= SYNC;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  side  <= 1'b0;
                  lsync <= 1'b1;
               end
               if (pend_valid) begin
                  act_len    <= pend_len;
                  act_sw     <= pend_sw;
                  act_pos    <= pend_pos;
                  act_gw     <= pend_gw;
                  pend_valid <= 1'b0;
                  cfg_ready  <= 1'b1;
               end
            end
            SYNC: begin
               if (cnt == sw_last) begin
                  state <= SWEEP;
                  lsync <= 1'b0;
                  rsync <= 1'b0;
                  dir   <= side;
                  cnt   <= '0;
                  pos_q <= pos_new;
                  end_q <= end_new;
                  sig   <= (pos_new == '0) && (end_new != '0);
`ifdef SCAN_JITTER_EN
                  lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                  jitter_ofs <= ofs4;
`endif
               end else begin
                  cnt <= cnt_inc;
               end
            end
            SWEEP: begin
               if (cnt == len_last) begin
                  sig         <= 1'b0;
                  sweep_count <= sweep_count + 32'd1;
                  cnt         <= '0;
                  if (enable) begin
                     state <= SYNC;
                     side  <= ~side;
                     lsync <= side;
                     rsync <= ~side;
                     if (pend_valid) begin
                        act_len    <= pend_len;
                        act_sw     <= pend_sw;
                        act_pos    <= pend_pos;
                        act_gw     <= pend_gw;
                        pend_valid <= 1'b0;
                        cfg_ready  <= 1'b1;
                     end
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     side  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt_inc;
                  sig <= sig_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scan_stimulus_gen.sv
// tb/tb_scan_stimulus_gen.sv - scoreboard bench for scan_stimulus_gen line edges and status
// Expected edges are queued with their cycle stamps; a negedge monitor matches observed edges.
module tb_scan_stimulus_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [23:0] cfg_sweep_len = '0;
   logic [15:0] cfg_sync_w = '0;
   logic [23:0] cfg_groove_pos = '0;
   logic [15:0] cfg_groove_w = '0;
   logic        lsync, rsync, sig, dir, busy;
   logic [31:0] sweep_count;
`ifdef SCAN_JITTER_EN
   logic [3:0]  jitter_ofs;
`endif

   scan_stimulus_gen dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_sweep_len(cfg_sweep_len), .cfg_sync_w(cfg_sync_w),
      .cfg_groove_pos(cfg_groove_pos), .cfg_groove_w(cfg_groove_w),
      .lsync(lsync), .rsync(rsync), .sig(sig), .dir(dir), .busy(busy),
      .sweep_count(sweep_count)
`ifdef SCAN_JITTER_EN
      , .jitter_ofs(jitter_ofs)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int code; int stamp; } ev_t;
   ev_t exp_q[$];
   int  cyc = 0;
   int  tests = 0;
   int  fails = 0;
   bit  mon_on = 1'b0;
   logic [3:0] prev_l, cur_l;

   always @(posedge clk) cyc <= cyc + 1;

   // Codes: 2*line + (0 rise / 1 fall); lines 0=lsync 1=rsync 2=sig 3=dir
   always @(negedge clk) begin
      cur_l = {dir, sig, rsync, lsync};
      if (mon_on) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_l[i] !== prev_l[i]) begin
               int code;
               int idx;
               code = 2 * i + (cur_l[i] ? 0 : 1);
               idx = -1;
               for (int k = 0; k < exp_q.size(); k++)
                  if (idx < 0 && exp_q[k].code == code && exp_q[k].stamp == cyc) idx = k;
               tests++;
               if (idx < 0) begin
                  fails++;
                  $display("FAIL edge: got unexpected edge code %0d at cycle %0d, required none", code, cyc);
               end else begin
                  exp_q.delete(idx);
               end
            end
         end
      end
      prev_l = cur_l;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int code, input int stamp);
      ev_t e;
      e.code = code;
      e.stamp = stamp;
      exp_q.push_back(e);
   endtask

   task automatic exp_sweep(input int y, input bit right, input int sw, input int dir_code,
                            input int sig_ofs, input int sig_w);
      push(right ? 2 : 0, y);
      push(right ? 3 : 1, y + sw);
      if (dir_code >= 0) push(dir_code, y + sw);
      if (sig_w > 0) begin
         push(4, y + sw + sig_ofs);
         push(5, y + sw + sig_ofs + sig_w);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic check_drained(input string name);
      if (exp_q.size() != 0)
         $display("  pending edge code %0d at cycle %0d", exp_q[0].code, exp_q[0].stamp);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_reset(input bit dir_was_high);
      if (dir_was_high) push(7, cyc + 1);
      enable = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic cfg_xfer(input int len, input int sw, input int pos, input int w);
      check("cfg_ready_before", cfg_ready, 1);
      cfg_sweep_len = 24'(len);
      cfg_sync_w = 16'(sw);
      cfg_groove_pos = 24'(pos);
      cfg_groove_w = 16'(w);
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("cfg_ready_drop", cfg_ready, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, y1, y2, y3;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_lsync", lsync, 0);
      check("rst_rsync", rsync, 0);
      check("rst_sig", sig, 0);
      check("rst_dir", dir, 0);
      check("rst_busy", busy, 0);
      check("rst_count", sweep_count, 0);
      check("rst_cfg_ready", cfg_ready, 1);
      mon_on = 1'b1;

      // Defaults, four sweeps L,R,L,R with period 1008
      enable = 1'b1;
      s = cyc + 1;
      exp_sweep(s,        0, 8, -1, 400, 20);
      exp_sweep(s + 1008, 1, 8,  6, 400, 20);
      exp_sweep(s + 2016, 0, 8,  7, 400, 20);
      exp_sweep(s + 3024, 1, 8,  6, 400, 20);
      wait_until(s + 1);
      check("busy_run", busy, 1);
      wait_until(s + 2016 + 10);
      check("count_2", sweep_count, 2);
      wait_until(s + 3024 + 500);
      enable = 1'b0;
      wait_until(s + 3024 + 1012);
      check("a_busy_idle", busy, 0);
      check("a_count_4", sweep_count, 4);
      check("a_lsync_low", lsync, 0);
      check("a_rsync_low", rsync, 0);
      check("a_dir", dir, 1);
      check_drained("a_edges");

      // Config handshake and boundary sweeps
      do_reset(1'b1);
      enable = 1'b1;
      s = cyc + 1;
      y1 = s + 1008;
      y2 = y1 + 208;
      y3 = y2 + 201;
      exp_sweep(s,  0, 8, -1, 400, 20);
      exp_sweep(y1, 1, 8,  6,  50, 10);
      exp_sweep(y2, 0, 1,  7, 190, 10);
      exp_sweep(y3, 1, 8,  6,   0,  0);
      wait_until(s + 100);
      cfg_xfer(200, 8, 50, 10);
      wait_until(s + 900);
      check("cfg_ready_held", cfg_ready, 0);
      wait_until(y1);
      check("cfg_ready_applied", cfg_ready, 1);
      wait_until(y1 + 20);
      cfg_xfer(200, 0, 190, 30);
      wait_until(y2 + 20);
      cfg_xfer(200, 8, 250, 10);
      wait_until(y3 + 50);
      enable = 1'b0;
      wait_until(y3 + 212);
      check("b_busy_idle", busy, 0);
      check("b_count_4", sweep_count, 4);
      check("b_sig_low", sig, 0);
      check_drained("b_edges");

      // Reset during rsync, then restart
      do_reset(1'b1);
      enable = 1'b1;
      s = cyc + 1;
      exp_sweep(s, 0, 8, -1, 400, 20);
      push(2, s + 1008);
      wait_until(s + 1010);
      check("c_rsync_high", rsync, 1);
      push(3, s + 1011);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("c_rst_rsync", rsync, 0);
      check("c_rst_lsync", lsync, 0);
      check("c_rst_sig", sig, 0);
      check("c_rst_busy", busy, 0);
      check("c_rst_count", sweep_count, 0);
      s = cyc + 1;
      exp_sweep(s, 0, 8, -1, 400, 20);
      wait_until(s + 3);
      check("c_restart_lsync", lsync, 1);
      check("c_restart_dir", dir, 0);
      wait_until(s + 500);
      enable = 1'b0;
      wait_until(s + 1012);
      check("c_count_1", sweep_count, 1);
      check("c_busy_idle", busy, 0);
      check_drained("c_edges");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/scan_stimulus_gen.md
# scan_stimulus_gen

Synthetic scanner front-end that drives the `lsync`, `rsync` and `sig` comparator lines normally produced by the optical head. It generates alternating left/right sync pulses, sweep intervals, and one programmable groove-edge pulse per sweep. It sits upstream of the preprocess block for bring-up, hardware-in-loop and closed-loop regression without a physical scanner.

## Interface
Parameters:
- `CW`, 24: width of all cycle counters and timing config fields.
- `DEF_SWEEP_LEN`, 24'd1000: sweep length after reset, in cycles.
- `DEF_SYNC_W`, 16'd8: sync pulse width after reset.
- `DEF_GROOVE_POS`, 24'd400: offset of the `sig` rise from the start of the sweep.
- `DEF_GROOVE_W`, 16'd20: `sig` high duration.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  run request.
- `cfg_valid`  in  1  new configuration offered.
- `cfg_ready`  out  1  configuration slot free.
- `cfg_sweep_len`  in  CW  cycles per sweep.
- `cfg_sync_w`  in  16  sync high width.
- `cfg_groove_pos`  in  CW  groove rise offset.
- `cfg_groove_w`  in  16  groove high width.
- `lsync`  out  1  left sync pulse.
- `rsync`  out  1  right sync pulse.
- `sig`  out  1  groove edge line.
- `dir`  out  1  0 = LTR sweep active, 1 = RTL.
- `busy`  out  1  FSM not IDLE.
- `sweep_count`  out  32  completed sweeps, wraps.

## Operation
- FSM states:
  - IDLE: wait for `enable`.
  - SYNC: the pulse toward the next sweep's side is high.
  - SWEEP: counting the sweep.
- Transitions:
  - IDLE → SYNC when `enable`=1. The first sync is `lsync` and the first sweep is LTR.
  - SYNC → SWEEP after `sync_w` cycles. A `sync_w` of 0 is treated as 1.
  - SWEEP → SYNC after `sweep_len` cycles when `enable`=1, otherwise SWEEP → IDLE. A `sweep_len` of 0 is treated as 1.
  - Every SWEEP exit increments `sweep_count` and toggles the side.
- Side handling:
  - LTR sweep is preceded by `lsync`; RTL sweep is preceded by `rsync`.
  - `dir` updates on the first cycle of SWEEP, matching the receiver, which toggles on the sync falling edge.
- `sig` during SWEEP:
  - `sig` = 1 when the sweep counter `c` is in [`groove_pos`, `groove_pos`+`groove_w`).
  - The end bound is computed in CW+1 bits and clamped to `sweep_len`.
  - `groove_w`=0 or `groove_pos` ≥ `sweep_len` produces no pulse that sweep.
  - `sig` is always 0 outside SWEEP.
- Config handshake:
  - A transfer occurs on `cfg_valid`&`cfg_ready`; the four fields are captured into a pending register.
  - `cfg_ready` drops until the pending register is applied to the active register.
  - Pending is applied on entry to SYNC, or in IDLE on the next cycle.
  - Active config is never changed mid-pulse or mid-sweep.
- `enable` is not re-sampled during a sweep. Deasserting it completes the current sync and sweep, then the FSM goes to IDLE with `lsync`/`rsync`/`sig` low.
- Restart from IDLE always begins with `lsync`/LTR.
- Reset:
  - All outputs go to 0 except `cfg_ready`=1; `dir`=0.
  - Active config is loaded from the parameters and pending is cleared.
  - Reset mid-pulse drops the lines on the next edge.

## Timing
- All outputs are registered.
- `enable` rising at edge N: `lsync`=1 from edge N+1 for `sync_w` cycles.
- The first SWEEP cycle (c=0) directly follows the last sync-high cycle.
- With no jitter, `sig` rises at edge (sync fall)+`groove_pos` and falls `groove_w` cycles later.
- Sync period = `sync_w`+`sweep_len` cycles, with no gap cycles.
- `cfg_ready` falls the cycle after a transfer and rises the cycle after apply.
- `busy`=1 from the edge after `enable` until the return to IDLE.

## Configuration
- `SCAN_JITTER_EN`, defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per sweep entry.
  - The effective groove position is `groove_pos` + (lfsr[3:0] − 8), saturated to [0, `sweep_len`−1].
  - The applied offset, a signed value in −8..+7, is exposed on an extra output `jitter_ofs` (4 bits).
- `SCAN_JITTER_EN`, undefined:
  - No LFSR and no `jitter_ofs` port.
  - The position is exactly `groove_pos`.

## Test plan
- Reset defaults, `enable`=1: `lsync` high for 8 cycles, then `sig` rises 400 cycles after the `lsync` fall and stays high 20 cycles. `rsync` rises 1000 cycles after the `lsync` fall, and `dir` flips to 1 when `rsync` falls.
- Run 4 sweeps: syncs alternate L,R,L,R; `sweep_count`=4; period 1008 cycles exactly.
- Config handshake: during the first sweep, transfer sweep_len=200, pos=50, w=10. Then:
  - `cfg_ready`=0 until the next SYNC.
  - The first sweep is unchanged.
  - The second sweep shows `sig` at offset 50, and the next sync follows 200 cycles later.
- Boundaries:
  - pos=190, w=30, len=200: `sig` high 10 cycles, low before sync.
  - pos=250: no `sig`.
  - sync_w=0: a 1-cycle sync pulse.
- Control interruptions:
  - Drop `enable` mid-sweep: the sweep completes, no further sync, `busy`=0.
  - Assert `reset` mid-`rsync`: all lines 0 next cycle.
  - Restart: begins with `lsync`, `dir`=0.
- Closed loop with the preprocess block, defaults:
  - `sig_time_L` delta between consecutive LTR sweeps = 2016.
  - Receiver `dir` tracks the generator `dir`.
  - With `SCAN_JITTER_EN`, the delta deviates by the logged `jitter_ofs` values only.
